pcie_us_rc_tag_router: RTL and testbench

- Tag allocator and completion router that sits in front of the UltraScale PCIe RC demultiplexer.
- Hands out PCIe request tags to M_COUNT requesters (DMA engines) through a round-robin arbiter and records which requester owns each tag.
- Decodes the tag field returned by the demux into its one-hot select/drop controls, so each completion reaches the engine that issued the request.
- Tags are returned to the free pool by an explicit release from the owning engine.

---
 rtl/pcie_us_rc_tag_router.sv | 138 +++++++++++++
 tb/tb_pcie_us_rc_tag_router.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_us_rc_tag_router.sv
// Tag allocator and completion router in front of the UltraScale PCIe RC demux.
// Hands out tags round-robin to requesters, records ownership, and steers completions.
module pcie_us_rc_tag_router #(
   parameter int unsigned M_COUNT   = 2,
   parameter int unsigned TAG_WIDTH = 8,
   parameter int unsigned TAG_COUNT = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [M_COUNT-1:0]               req,
   output logic [M_COUNT-1:0]               gnt,
   output logic [TAG_WIDTH-1:0]             gnt_tag,
   input  logic                             release_valid,
   input  logic [TAG_WIDTH-1:0]             release_tag,
   input  logic [TAG_WIDTH-1:0]             requester_id,
   input  logic                             enable,
   output logic                             demux_enable,
   output logic                             demux_drop,
   output logic [M_COUNT-1:0]               demux_select,
   output logic [$clog2(TAG_COUNT+1)-1:0]   free_count,
   output logic                             err_release,
   output logic                             err_tag
);

   localparam int unsigned OWNER_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
   localparam int unsigned IDX_W   = (TAG_COUNT > 1) ? $clog2(TAG_COUNT) : 1;
   localparam int unsigned CNT_W   = $clog2(TAG_COUNT + 1);
   localparam logic [TAG_WIDTH:0] TAG_LIMIT = (TAG_WIDTH + 1)'(TAG_COUNT);

   logic [TAG_COUNT-1:0] alloc_valid_q, alloc_valid_d;
   logic [OWNER_W-1:0]   owner_q [TAG_COUNT];
   logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [M_COUNT-1:0]   gnt_q, gnt_d;
   logic [TAG_WIDTH-1:0] gnt_tag_q, gnt_tag_d;
   logic [CNT_W-1:0]     free_count_q, free_count_d;
   logic                 err_release_q, err_release_d;

   logic [M_COUNT-1:0]   eligible;
   logic                 free_any, win_any, do_alloc, do_release, rel_hit, rid_hit;
   logic [IDX_W-1:0]     free_idx, rel_idx, rid_idx;
   logic [OWNER_W-1:0]   win_idx, cand;

   // Lowest-index free tag
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      for (int i = int'(TAG_COUNT) - 1; i >= 0; i--) begin
         if (!alloc_valid_q[i]) begin
            free_any = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   // Round-robin search upward from rr_ptr+1; a requester granted last cycle is masked
   always_comb begin
      eligible = req & ~gnt_q;
      win_any  = 1'b0;
      win_idx  = '0;
      cand     = '0;
      for (int k = int'(M_COUNT); k >= 1; k--) begin
         cand = OWNER_W'((int'(rr_ptr_q) + k) % int'(M_COUNT));
         if (eligible[cand]) begin
            win_any = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      rel_idx = IDX_W'(release_tag);
      rel_hit = ({1'b0, release_tag} < TAG_LIMIT) && alloc_valid_q[rel_idx];
      rid_idx = IDX_W'(requester_id);
      rid_hit = ({1'b0, requester_id} < TAG_LIMIT) && alloc_valid_q[rid_idx];
   end

   // Next-state: allocation selects from the pre-release vector
   always_comb begin
      do_alloc      = free_any && win_any;
      do_release    = release_valid && rel_hit;
      alloc_valid_d = alloc_valid_q;
      rr_ptr_d      = rr_ptr_q;
      gnt_d         = '0;
      gnt_tag_d     = gnt_tag_q;
      free_count_d  = free_count_q;
      err_release_d = release_valid && !rel_hit;
      if (do_release) alloc_valid_d[rel_idx] = 1'b0;
      if (do_alloc) begin
         alloc_valid_d[free_idx] = 1'b1;
         gnt_d[win_idx]          = 1'b1;
         gnt_tag_d               = TAG_WIDTH'(free_idx);
         rr_ptr_d                = win_idx;
      end
      case ({do_alloc, do_release})
         2'b10:   free_count_d = free_count_q - CNT_W'(1);
         2'b01:   free_count_d = free_count_q + CNT_W'(1);
         default: free_count_d = free_count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alloc_valid_q <= '0;
         rr_ptr_q      <= OWNER_W'(M_COUNT - 1);
         gnt_q         <= '0;
         gnt_tag_q     <= '0;
         free_count_q  <= CNT_W'(TAG_COUNT);
         err_release_q <= 1'b0;
      end else begin
         alloc_valid_q <= alloc_valid_d;
         rr_ptr_q      <= rr_ptr_d;
         gnt_q         <= gnt_d;
         gnt_tag_q     <= gnt_tag_d;
         free_count_q  <= free_count_d;
         err_release_q <= err_release_d;
      end
   end

   // Owner table needs no reset: entries are only read while their alloc bit is set
   always_ff @(posedge clk) begin
      if (do_alloc) owner_q[free_idx] <= win_idx;
   end

   // Routing sees pre-release state so the final beat of a released tag still hits
   always_comb begin
      demux_select = '0;
      if (rid_hit) demux_select[owner_q[rid_idx]] = 1'b1;
      demux_drop   = !rid_hit;
      err_tag      = !rid_hit;
      demux_enable = enable && !rst;
   end

   assign gnt         = gnt_q;
   assign gnt_tag     = gnt_tag_q;
   assign free_count  = free_count_q;
   assign err_release = err_release_q;

endmodule

// File: tb/tb_pcie_us_rc_tag_router.sv
// Directed bench for pcie_us_rc_tag_router: grants are scoreboarded through a queue,
// routing, counters and error flags are checked inline.
module tb_pcie_us_rc_tag_router;

   localparam int unsigned M  = 2;
   localparam int unsigned TW = 8;
   localparam int unsigned TC = 32;
   localparam int unsigned CW = $clog2(TC + 1);

   logic          clk;
   logic          rst;
   logic [M-1:0]  req;
   logic [M-1:0]  gnt;
   logic [TW-1:0] gnt_tag;
   logic          release_valid;
   logic [TW-1:0] release_tag;
   logic [TW-1:0] requester_id;
   logic          enable;
   logic          demux_enable;
   logic          demux_drop;
   logic [M-1:0]  demux_select;
   logic [CW-1:0] free_count;
   logic          err_release;
   logic          err_tag;

   pcie_us_rc_tag_router #(.M_COUNT(M), .TAG_WIDTH(TW), .TAG_COUNT(TC)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_tag(gnt_tag),
      .release_valid(release_valid), .release_tag(release_tag),
      .requester_id(requester_id), .enable(enable),
      .demux_enable(demux_enable), .demux_drop(demux_drop),
      .demux_select(demux_select), .free_count(free_count),
      .err_release(err_release), .err_tag(err_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [M-1:0]  g;
      logic [TW-1:0] t;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic expect_gnt(input logic [M-1:0] g, input logic [TW-1:0] t);
      exp_t e;
      e.g = g;
      e.t = t;
      exp_q.push_back(e);
   endtask

   // Grant scoreboard: every grant must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && gnt !== '0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_gnt", 32'(gnt), 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("gnt", 32'(gnt), 32'(mon_e.g));
            chk("gnt_tag", 32'(gnt_tag), 32'(mon_e.t));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; req = '0; release_valid = 1'b0; release_tag = '0;
      requester_id = '0; enable = 1'b1;
      tick();
      tick();
      chk("demux_enable_in_rst", 32'(demux_enable), 0);
      rst = 1'b0;
      #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_gnt_tag", 32'(gnt_tag), 0);
      chk("rst_free_count", 32'(free_count), 32);
      chk("rst_err_release", 32'(err_release), 0);
      chk("rst_drop", 32'(demux_drop), 1);
      chk("rst_select", 32'(demux_select), 0);
      chk("rst_err_tag", 32'(err_tag), 1);
      chk("demux_enable", 32'(demux_enable), 1);

      // Single requester, first grant
      req = 2'b01;
      expect_gnt(2'b01, 8'd0);
      tick();
      req = '0;
      chk("free_after_first", 32'(free_count), 31);
      requester_id = 8'd0;
      #1;
      chk("route0_select", 32'(demux_select), 1);
      chk("route0_drop", 32'(demux_drop), 0);
      chk("route0_err_tag", 32'(err_tag), 0);
      tick();
      chk("no_regrant", 32'(gnt), 0);
      chk("sb_empty_1", 32'(exp_q.size()), 0);

      // Fresh state, both requesters alternate
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 2'b11;
      expect_gnt(2'b01, 8'd0);
      expect_gnt(2'b10, 8'd1);
      expect_gnt(2'b01, 8'd2);
      expect_gnt(2'b10, 8'd3);
      repeat (4) tick();
      req = '0;
      chk("free_after_rr", 32'(free_count), 28);
      requester_id = 8'd1;
      #1;
      chk("route1_select", 32'(demux_select), 2);
      requester_id = 8'd2;
      #1;
      chk("route2_select", 32'(demux_select), 1);
      chk("sb_empty_2", 32'(exp_q.size()), 0);
      tick();
      chk("gnt_idle", 32'(gnt), 0);

      // Exhaust the pool
      for (int t = 4; t < int'(TC); t++)
         expect_gnt(((t % 2) == 0) ? 2'b01 : 2'b10, TW'(t));
      req = 2'b11;
      for (int i = 0; i < 200 && free_count != '0; i++) tick();
      chk("free_empty", 32'(free_count), 0);
      chk("sb_empty_3", 32'(exp_q.size()), 0);
      repeat (3) begin
         tick();
         chk("gnt_when_empty", 32'(gnt), 0);
      end

      // Released tag becomes grantable one cycle after the release edge
      release_valid = 1'b1;
      release_tag   = 8'd5;
      expect_gnt(2'b01, 8'd5);
      tick();
      release_valid = 1'b0;
      chk("no_early_gnt", 32'(gnt), 0);
      chk("sb_pending", 32'(exp_q.size()), 1);
      chk("free_after_rel5", 32'(free_count), 1);
      tick();
      req = '0;
      chk("sb_empty_4", 32'(exp_q.size()), 0);
      chk("free_after_regrant", 32'(free_count), 0);

      // Valid release, then invalid releases
      release_valid = 1'b1;
      release_tag   = 8'd7;
      tick();
      chk("err_rel_valid", 32'(err_release), 0);
      chk("free_after_rel7", 32'(free_count), 1);
      tick();
      chk("err_rel_unalloc", 32'(err_release), 1);
      chk("free_unalloc", 32'(free_count), 1);
      release_tag = 8'd40;
      tick();
      chk("err_rel_range", 32'(err_release), 1);
      chk("free_range", 32'(free_count), 1);
      release_valid = 1'b0;
      tick();
      chk("err_rel_pulse_end", 32'(err_release), 0);
      chk("free_stable", 32'(free_count), 1);

      // Miss path
      release_valid = 1'b1;
      release_tag   = 8'd9;
      tick();
      release_valid = 1'b0;
      chk("free_after_rel9", 32'(free_count), 2);
      requester_id = 8'd9;
      #1;
      chk("miss9_drop", 32'(demux_drop), 1);
      chk("miss9_select", 32'(demux_select), 0);
      chk("miss9_err_tag", 32'(err_tag), 1);
      requester_id = 8'd40;
      #1;
      chk("miss40_drop", 32'(demux_drop), 1);
      requester_id = 8'd10;
      #1;
      chk("route10_select", 32'(demux_select), 1);
      chk("route10_drop", 32'(demux_drop), 0);

      // Lookup of a tag released in the same cycle still hits
      requester_id  = 8'd3;
      release_valid = 1'b1;
      release_tag   = 8'd3;
      #1;
      chk("route_on_release_sel", 32'(demux_select), 2);
      chk("route_on_release_drop", 32'(demux_drop), 0);
      tick();
      release_valid = 1'b0;
      #1;
      chk("route_after_release_drop", 32'(demux_drop), 1);
      chk("route_after_release_err", 32'(err_tag), 1);
      chk("free_after_rel3", 32'(free_count), 3);

      // Reset in the middle of a burst
      req = 2'b11;
      expect_gnt(2'b10, 8'd3);
      tick();
      chk("sb_empty_5", 32'(exp_q.size()), 0);
      rst = 1'b1;
      tick();
      chk("midrst_gnt", 32'(gnt), 0);
      chk("midrst_free", 32'(free_count), 32);
      chk("midrst_demux_enable", 32'(demux_enable), 0);
      requester_id = 8'd3;
      #1;
      chk("midrst_drop3", 32'(demux_drop), 1);
      requester_id = 8'd10;
      #1;
      chk("midrst_drop10", 32'(demux_drop), 1);
      chk("midrst_select10", 32'(demux_select), 0);
      rst = 1'b0;
      req = '0;
      tick();
      chk("postrst_gnt", 32'(gnt), 0);
      chk("postrst_free", 32'(free_count), 32);
      chk("postrst_demux_enable", 32'(demux_enable), 1);
      chk("sb_empty_final", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
